// File: rtl/cc_pipeline_pkg.sv
// Shared definitions for the cross-correlation pipeline: scheduler states, packet constants.
// CC_SCHED_CHECKSUM_EN adds the trailing checksum state and byte.
package cc_pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_PAIR,
    ST_WAIT_CC,
    ST_NEXT_PAIR,
    ST_SEND_HDR,
    ST_SEND_IDX,
`ifdef CC_SCHED_CHECKSUM_EN
    ST_SEND_CSUM,
`endif
    ST_DONE
  } sched_state_t;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam logic [7:0] TIMEOUT_MARK = 8'hFF;

`ifdef CC_SCHED_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // Header byte, one byte per pair, plus an optional checksum byte.
  function automatic int pkt_len(input int num_pairs, input bit csum_en);
    return num_pairs + 1 + (csum_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/general_counter.sv
// General-purpose up counter: select low forces zero, select high counts and holds at COUNT_VAL-1.
module general_counter #(
  parameter int COUNT_VAL = 16,
  parameter int CNT_W     = $clog2(COUNT_VAL) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_sel,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || !cnt_sel) begin
      count <= '0;
    end else if (count != CNT_W'(COUNT_VAL - 1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cc_pair_scheduler.sv
// Runs the CC block over every channel pair after a trigger, then streams the lag packet to UART TX.
// Define CC_SCHED_CHECKSUM_EN to append an XOR checksum byte to the packet.
module cc_pair_scheduler
  import cc_pipeline_pkg::*;
#(
  parameter int         NUM_PAIRS   = 3,
  parameter int         PAIR_W      = 2,
  parameter int         IDX_W       = 8,
  parameter int         WDOG_CYCLES = 200000,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cc_start,
  output logic [PAIR_W-1:0] cc_pair_sel,
  input  logic              cc_done,
  input  logic [IDX_W-1:0]  cc_max_index,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              wdog_err
);

  localparam int PKT_LEN = pkt_len(NUM_PAIRS, CSUM_EN);
  localparam int PTR_W   = $clog2(PKT_LEN + 1);
  localparam int WD_W    = $clog2(WDOG_CYCLES) + 1;

  localparam logic [PAIR_W-1:0] LAST_PAIR    = PAIR_W'(NUM_PAIRS - 1);
  localparam logic [PTR_W-1:0]  LAST_IDX_PTR = PTR_W'(NUM_PAIRS);

  sched_state_t      state, state_nxt;
  logic [PAIR_W-1:0] pair, pair_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [7:0]        result [NUM_PAIRS];
  logic [WD_W-1:0]   wdog_cnt;
  logic              wdog_run;
  logic              wdog_exp;
  logic              cap_hit;
  logic              tmo_hit;

  // The watchdog only runs in WAIT_CC; every other state holds it at zero.
  assign wdog_run = (state == ST_WAIT_CC);

  general_counter #(
    .COUNT_VAL (WDOG_CYCLES),
    .CNT_W     (WD_W)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .cnt_sel (wdog_run),
    .count   (wdog_cnt)
  );

  assign wdog_exp = (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
  assign cap_hit  = (state == ST_WAIT_CC) && cc_done;
  assign tmo_hit  = (state == ST_WAIT_CC) && !cc_done && wdog_exp;

  always_comb begin
    state_nxt = state;
    pair_nxt  = pair;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_START_PAIR;
          pair_nxt  = '0;
        end
      end
      ST_START_PAIR: state_nxt = ST_WAIT_CC;
      ST_WAIT_CC: begin
        if (cc_done || wdog_exp) state_nxt = ST_NEXT_PAIR;
      end
      ST_NEXT_PAIR: begin
        if (pair == LAST_PAIR) begin
          state_nxt = ST_SEND_HDR;
          ptr_nxt   = '0;
        end else begin
          state_nxt = ST_START_PAIR;
          pair_nxt  = pair + 1'b1;
        end
      end
      ST_SEND_HDR: begin
        if (tx_ready) begin
          state_nxt = ST_SEND_IDX;
          ptr_nxt   = PTR_W'(1);
        end
      end
      ST_SEND_IDX: begin
        if (tx_ready) begin
          if (ptr == LAST_IDX_PTR) begin
`ifdef CC_SCHED_CHECKSUM_EN
            state_nxt = ST_SEND_CSUM;
            ptr_nxt   = ptr + 1'b1;
`else
            state_nxt = ST_DONE;
`endif
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
`ifdef CC_SCHED_CHECKSUM_EN
      ST_SEND_CSUM: begin
        if (tx_ready) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CC_SCHED_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = HDR_BYTE;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      csum = csum ^ result[i];
    end
  end
`endif

  // Byte mux is driven purely by state and pointer, so it cannot move during a stall.
  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    case (state)
      ST_SEND_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
      end
      ST_SEND_IDX: begin
        tx_valid = 1'b1;
        for (int i = 0; i < NUM_PAIRS; i++) begin
          if (ptr == PTR_W'(i + 1)) tx_data = result[i];
        end
      end
`ifdef CC_SCHED_CHECKSUM_EN
      ST_SEND_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
      end
`endif
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  assign cc_start    = (state == ST_START_PAIR);
  assign cc_pair_sel = pair;
  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign done        = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pair     <= '0;
      ptr      <= '0;
      wdog_err <= 1'b0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
        result[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      pair  <= pair_nxt;
      ptr   <= ptr_nxt;
      if ((state == ST_IDLE) && start) begin
        wdog_err <= 1'b0;
      end else if (tmo_hit) begin
        wdog_err <= 1'b1;
      end
      for (int i = 0; i < NUM_PAIRS; i++) begin
        if (pair == PAIR_W'(i)) begin
          if (cap_hit) begin
            result[i] <= 8'(cc_max_index);
          end else if (tmo_hit) begin
            result[i] <= TIMEOUT_MARK;
          end
        end
      end
    end
  end

endmodule

// File: doc/cc_pair_scheduler.md
Name: cc_pair_scheduler

Overview:
- Sequences the cross-correlation datapath over every hydrophone channel pair after a trigger.
- For each pair: selects the pair, pulses the CC start, waits for done, captures the argmax lag index.
- Then streams a result packet to the UART TX byte interface over a valid/ready handshake.
- Sits between the pipeline controller and the CC block / UART TX; the pipeline controller's TX enable is replaced by this block's done pulse.

Parameters:
- NUM_PAIRS, 3, number of channel pairs correlated per ping (1..15).
- PAIR_W, 2, width of cc_pair_sel; must satisfy 2**PAIR_W >= NUM_PAIRS.
- IDX_W, 8, width of the CC max index (1..8); zero-extended to 8 bits on TX.
- WDOG_CYCLES, 200000, per-pair CC watchdog limit in clk cycles (2 ms at 100 MHz).
- HDR_BYTE, 8'hA5, packet header byte.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the pipeline controller (its Start_CC).
- cc_start  out  1  one-cycle start pulse to the CC block.
- cc_pair_sel  out  PAIR_W  channel pair currently being correlated.
- cc_done  in  1  one-cycle done pulse from the CC block.
- cc_max_index  in  IDX_W  argmax lag; valid in the cycle cc_done is high.
- tx_valid  out  1  byte valid toward UART TX.
- tx_data  out  8  byte toward UART TX.
- tx_ready  in  1  UART TX accepts the byte.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last packet byte is accepted.
- wdog_err  out  1  sticky; set if any pair timed out. Cleared on the next accepted start or on reset.

Behaviour:
- Reset (synchronous, active-high, on any cycle including mid-operation):
  - State returns to IDLE.
  - cc_start, tx_valid, busy, done and wdog_err go to 0; tx_data and cc_pair_sel go to 0.
  - Result registers and the watchdog clear.
  - Any partial packet is abandoned; no further bytes are sent.
- States: IDLE, START_PAIR, WAIT_CC, NEXT_PAIR, SEND_HDR, SEND_IDX, DONE.
- IDLE:
  - start=1 -> START_PAIR, pair=0, wdog_err cleared.
  - start is ignored in every other state.
- START_PAIR:
  - cc_start=1 for exactly this cycle; cc_pair_sel=pair, held stable through WAIT_CC.
  - Watchdog clears to 0; next state WAIT_CC.
- WAIT_CC:
  - Watchdog increments each cycle.
  - cc_done=1 -> capture cc_max_index into result[pair], go to NEXT_PAIR.
  - Else if watchdog == WDOG_CYCLES-1 -> result[pair]=8'hFF, set wdog_err, go to NEXT_PAIR.
  - cc_done and watchdog expiry in the same cycle: done wins, index is captured, no error.
  - cc_done outside WAIT_CC is ignored.
- NEXT_PAIR:
  - pair == NUM_PAIRS-1 -> SEND_HDR, byte pointer=0.
  - Else pair+1 -> START_PAIR.
  - There is a 1-cycle bubble between pairs.
- Latency: start in cycle 0 -> cc_start in cycle 1 -> earliest capture in cycle 2 if cc_done arrives in cycle 2.
- SEND_HDR / SEND_IDX:
  - tx_valid=1; tx_data=HDR_BYTE, then result[0..NUM_PAIRS-1], each zero-extended from IDX_W.
  - A byte transfers when tx_valid && tx_ready.
  - tx_data and tx_valid must not change while tx_valid && !tx_ready.
  - Back-to-back bytes are allowed with tx_ready held at 1.
  - After the last result byte is accepted -> DONE.
- DONE: done=1 for one cycle, tx_valid=0 -> IDLE.
- busy: 1 in every state except IDLE; 0 in the DONE cycle.
- Pair counter and byte pointer never wrap past NUM_PAIRS (or NUM_PAIRS+1 with the optional feature enabled).

Optional Feature:
- Macro: CC_SCHED_CHECKSUM_EN.
- When defined: after the last result byte, a SEND_CSUM state sends one more byte. Its value is the XOR of HDR_BYTE and all result bytes. Same handshake rules; DONE follows its acceptance. Packet length becomes NUM_PAIRS+2.
- When undefined: no checksum state or logic; packet length is NUM_PAIRS+1.

Decomposition:
- Shared package cc_pipeline_pkg holds:
  - state encoding constants;
  - HDR_BYTE default;
  - the 8'hFF timeout marker;
  - the packet-length function (NUM_PAIRS, checksum flag).
- Watchdog implemented by instantiating the existing general counter module with COUNT_VAL=WDOG_CYCLES, controlled through its zero/count select. No new sub-module.

Test Plan:
- Nominal, NUM_PAIRS=3, CC model returns 8'h10, 8'h22, 8'h3F with 5-cycle latency each, tx_ready=1:
  - exactly 3 cc_start pulses with cc_pair_sel=0,1,2;
  - bytes A5,10,22,3F;
  - done pulses once; wdog_err=0.
- Backpressure: tx_ready toggled 1,0,0,1 repeatedly -> tx_data/tx_valid stable during stalls; byte sequence identical to nominal; no byte duplicated or dropped.
- Watchdog: pair 1 never returns cc_done, WDOG_CYCLES=50:
  - expiry after 50 cycles in WAIT_CC;
  - bytes A5,10,FF,3F; wdog_err=1 until the next start.
- Collisions:
  - cc_done coincident with the final watchdog cycle -> index captured, wdog_err=0.
  - start pulsed mid-sequence -> ignored, no extra cc_start.
- Reset mid-operation: reset during SEND_IDX after 2 bytes -> next cycle tx_valid=0, busy=0; a fresh start produces a complete correct packet.
- CC_SCHED_CHECKSUM_EN defined, nominal stimulus -> bytes A5,10,22,3F,A8 (XOR), then done.
